// File: rtl/uart_rx_parity.sv
// uart_rx_parity: 8E1 UART receiver with parity and framing error flags.
// Input passes through a 2-flop synchroniser; sampling happens at mid-bit.
module uart_rx_parity #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            hold_q, hold_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;

    assign rx_s       = sync_q[1];
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = state_q != IDLE;

    always_comb begin
        sync_d    = {sync_q[0], rx_in};
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        hold_d    = hold_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // After a low stop bit, wait for the line to return high before hunting for a start
                if (hold_q) hold_d = ~rx_s;
                else if (!rx_s) state_d = START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL) begin
                cnt_d            = '0;
                shift_d[bit_idx_q] = rx_s;
                bit_idx_d        = bit_idx_q + 1'b1;
                if (bit_idx_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (cnt_q == FULL) begin
                cnt_d   = '0;
                par_d   = rx_s;
                state_d = STOP;
            end
            STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                data_d  = shift_q;
                perr_d  = par_q != ^shift_q;
                ferr_d  = ~rx_s;
                valid_d = 1'b1;
                hold_d  = ~rx_s;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            hold_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end
endmodule
